// File: rtl/fetch_queue.sv
// Multi-entry ready/valid buffer carrying {PC, instruction} from fetch to decode.
// It has a circular buffer with arbitrary depth, supports simultaneous push/pop,
// and provides a synchronous flush. A NOP payload is presented whenever it is empty.
`timescale 1ns/1ps
module fetch_queue #(
    parameter int InstrWidth = 32,
    parameter int PcWidth    = 64,
    parameter int Depth      = 2,
    parameter logic [InstrWidth-1:0] NopInstr = InstrWidth'(32'h0000_0013),
    localparam int CntWidth  = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  pipeline_flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [InstrWidth-1:0] instruction_i,
    input  logic [PcWidth-1:0]    PC_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [InstrWidth-1:0] instruction_o,
    output logic [PcWidth-1:0]    PC_o,
    output logic [CntWidth-1:0]   occupancy_o
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [PcWidth+InstrWidth-1:0] mem_q [Depth];
    logic push, pop;

    // Pointers wrap explicitly at Depth-1 so non-power-of-2 depths work.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // ready_o depends only on registered count, never on ready_i.
    assign ready_o     = (count_q != FullCnt);
    assign valid_o     = (count_q != '0);
    assign push        = valid_i & ready_o;
    assign pop         = valid_o & ready_i;
    assign occupancy_o = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (pipeline_flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is left uninitialised; it is masked by the empty check below.
    always_ff @(posedge clk_i) begin
        if (push && !pipeline_flush_i) begin
            mem_q[wptr_q] <= {PC_i, instruction_i};
        end
    end

    always_comb begin
        instruction_o = NopInstr;
        PC_o          = '0;
        if (valid_o) begin
            {PC_o, instruction_o} = mem_q[rptr_q];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue using Depth 2, 3 and 4 instances on a shared clock and reset.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic        d2_flush, d2_valid_i, d2_ready_i, d2_ready_o, d2_valid_o;
    logic [31:0] d2_instr_i, d2_instr_o;
    logic [63:0] d2_pc_i, d2_pc_o;
    logic [1:0]  d2_occ;

    logic        d3_flush, d3_valid_i, d3_ready_i, d3_ready_o, d3_valid_o;
    logic [31:0] d3_instr_i, d3_instr_o;
    logic [63:0] d3_pc_i, d3_pc_o;
    logic [1:0]  d3_occ;

    logic        d4_flush, d4_valid_i, d4_ready_i, d4_ready_o, d4_valid_o;
    logic [31:0] d4_instr_i, d4_instr_o;
    logic [63:0] d4_pc_i, d4_pc_o;
    logic [2:0]  d4_occ;

    fetch_queue #(.Depth(2)) u_d2 (
        .clk_i(clk), .reset_ni(reset_n), .pipeline_flush_i(d2_flush),
        .valid_i(d2_valid_i), .ready_o(d2_ready_o), .instruction_i(d2_instr_i), .PC_i(d2_pc_i),
        .valid_o(d2_valid_o), .ready_i(d2_ready_i), .instruction_o(d2_instr_o), .PC_o(d2_pc_o),
        .occupancy_o(d2_occ)
    );

    fetch_queue #(.Depth(3)) u_d3 (
        .clk_i(clk), .reset_ni(reset_n), .pipeline_flush_i(d3_flush),
        .valid_i(d3_valid_i), .ready_o(d3_ready_o), .instruction_i(d3_instr_i), .PC_i(d3_pc_i),
        .valid_o(d3_valid_o), .ready_i(d3_ready_i), .instruction_o(d3_instr_o), .PC_o(d3_pc_o),
        .occupancy_o(d3_occ)
    );

    fetch_queue #(.Depth(4)) u_d4 (
        .clk_i(clk), .reset_ni(reset_n), .pipeline_flush_i(d4_flush),
        .valid_i(d4_valid_i), .ready_o(d4_ready_o), .instruction_i(d4_instr_i), .PC_i(d4_pc_i),
        .valid_o(d4_valid_o), .ready_i(d4_ready_i), .instruction_o(d4_instr_o), .PC_o(d4_pc_o),
        .occupancy_o(d4_occ)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_instr(input logic [63:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic idle_all;
        d2_flush = 0; d2_valid_i = 0; d2_ready_i = 0; d2_instr_i = '0; d2_pc_i = '0;
        d3_flush = 0; d3_valid_i = 0; d3_ready_i = 0; d3_instr_i = '0; d3_pc_i = '0;
        d4_flush = 0; d4_valid_i = 0; d4_ready_i = 0; d4_instr_i = '0; d4_pc_i = '0;
    endtask

    task automatic push_d4(input logic [63:0] pc);
        d4_valid_i = 1'b1; d4_pc_i = pc; d4_instr_i = mk_instr(pc);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle_all();
        #2;
        checks++; if (d4_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", d4_valid_o); end
        checks++; if (d4_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", d4_ready_o); end
        checks++; if (d4_occ !== 3'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", d4_occ); end
        checks++; if (d4_instr_o !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", d4_instr_o, NOP); end
        checks++; if (d4_pc_o !== 64'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", d4_pc_o); end
        checks++; if (d2_ready_o !== 1'b1 || d2_valid_o !== 1'b0) begin errors++; $display("FAIL rst_d2 got r%0b v%0b exp r1 v0", d2_ready_o, d2_valid_o); end
        checks++; if (d3_ready_o !== 1'b1 || d3_valid_o !== 1'b0) begin errors++; $display("FAIL rst_d3 got r%0b v%0b exp r1 v0", d3_ready_o, d3_valid_o); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (d4_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %0b exp 1", i, d4_ready_o); end
            checks++; if (d4_occ !== 3'(i)) begin errors++; $display("FAIL fill_occ_%0d got %0d exp %0d", i, d4_occ, i); end
            push_d4(64'h100 + 64'(4 * i));
            d4_ready_i = 1'b0;
        end
        @(negedge clk);
        d4_valid_i = 1'b0;
        checks++; if (d4_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", d4_ready_o); end
        checks++; if (d4_occ !== 3'd4) begin errors++; $display("FAIL full_occ got %0d exp 4", d4_occ); end
        d4_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (d4_pc_o !== 64'h100 + 64'(4 * i)) begin errors++; $display("FAIL drain_pc_%0d got %h exp %h", i, d4_pc_o, 64'h100 + 64'(4 * i)); end
            checks++; if (d4_instr_o !== mk_instr(64'h100 + 64'(4 * i))) begin errors++; $display("FAIL drain_instr_%0d got %h", i, d4_instr_o); end
            checks++; if (d4_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d got %0b exp 1", i, d4_valid_o); end
            if (i == 1) begin
                checks++; if (d4_ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready_after_pop got %0b exp 1", d4_ready_o); end
            end
            @(negedge clk);
        end
        d4_ready_i = 1'b0;
        checks++; if (d4_valid_o !== 1'b0) begin errors++; $display("FAIL drained_valid got %0b exp 0", d4_valid_o); end
        checks++; if (d4_occ !== 3'd0) begin errors++; $display("FAIL drained_occ got %0d exp 0", d4_occ); end
        checks++; if (d4_instr_o !== NOP) begin errors++; $display("FAIL drained_instr got %h exp %h", d4_instr_o, NOP); end
        checks++; if (d4_pc_o !== 64'h0) begin errors++; $display("FAIL drained_pc got %h exp 0", d4_pc_o); end
    endtask

    task automatic test_streaming;
        @(negedge clk);
        d2_valid_i = 1'b1; d2_ready_i = 1'b1;
        d2_pc_i = 64'h1000; d2_instr_i = mk_instr(64'h1000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (d2_occ !== 2'd1) begin errors++; $display("FAIL stream_occ_%0d got %0d exp 1", c, d2_occ); end
            checks++; if (d2_ready_o !== 1'b1 || d2_valid_o !== 1'b1) begin errors++; $display("FAIL stream_hs_%0d got r%0b v%0b exp r1 v1", c, d2_ready_o, d2_valid_o); end
            checks++; if (d2_pc_o !== 64'h1000 + 64'(4 * c)) begin errors++; $display("FAIL stream_pc_%0d got %h exp %h", c, d2_pc_o, 64'h1000 + 64'(4 * c)); end
            d2_pc_i = 64'h1000 + 64'(4 * (c + 1));
            d2_instr_i = mk_instr(d2_pc_i);
        end
        @(negedge clk);
        d2_valid_i = 1'b0;
        checks++; if (d2_pc_o !== 64'h1050 || d2_occ !== 2'd1) begin errors++; $display("FAIL stream_last got pc %h occ %0d exp pc 1050 occ 1", d2_pc_o, d2_occ); end
        @(negedge clk);
        d2_ready_i = 1'b0;
        checks++; if (d2_occ !== 2'd0) begin errors++; $display("FAIL stream_empty got %0d exp 0", d2_occ); end
    endtask

    task automatic test_wrap;
        int cnt = 0, in_idx = 0, out_idx = 0, cyc = 0, max_occ = 0;
        logic push_m, pop_m;
        while (out_idx < 7 && cyc < 40) begin
            @(negedge clk);
            checks++; if (d3_occ !== 2'(cnt)) begin errors++; $display("FAIL wrap_occ_c%0d got %0d exp %0d", cyc, d3_occ, cnt); end
            checks++; if (d3_ready_o !== (cnt != 3)) begin errors++; $display("FAIL wrap_ready_c%0d got %0b exp %0b", cyc, d3_ready_o, cnt != 3); end
            if (cnt != 0) begin
                checks++; if (d3_pc_o !== 64'h2000 + 64'(4 * out_idx)) begin errors++; $display("FAIL wrap_pc_c%0d got %h exp %h", cyc, d3_pc_o, 64'h2000 + 64'(4 * out_idx)); end
            end
            if (int'(d3_occ) > max_occ) max_occ = int'(d3_occ);
            d3_valid_i = (in_idx < 7);
            d3_pc_i    = 64'h2000 + 64'(4 * in_idx);
            d3_instr_i = mk_instr(d3_pc_i);
            d3_ready_i = cyc[0];
            push_m = d3_valid_i && (cnt != 3);
            pop_m  = d3_ready_i && (cnt != 0);
            in_idx  += int'(push_m);
            out_idx += int'(pop_m);
            cnt      = cnt + int'(push_m) - int'(pop_m);
            cyc++;
        end
        checks++; if (out_idx != 7) begin errors++; $display("FAIL wrap_timeout got %0d pops exp 7", out_idx); end
        @(negedge clk);
        d3_valid_i = 1'b0; d3_ready_i = 1'b0;
        checks++; if (d3_occ !== 2'd0 || d3_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_empty got occ %0d v %0b exp 0 0", d3_occ, d3_valid_o); end
        checks++; if (max_occ != 3) begin errors++; $display("FAIL wrap_max_occ got %0d exp 3", max_occ); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push_d4(64'h300 + 64'(4 * i));
            d4_ready_i = 1'b0;
        end
        @(negedge clk);
        checks++; if (d4_occ !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got %0d exp 3", d4_occ); end
        d4_flush = 1'b1; d4_ready_i = 1'b1;
        push_d4(64'h200);
        @(negedge clk);
        d4_flush = 1'b0; d4_valid_i = 1'b0;
        checks++; if (d4_occ !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", d4_occ); end
        checks++; if (d4_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", d4_valid_o); end
        checks++; if (d4_instr_o !== NOP) begin errors++; $display("FAIL flush_instr got %h exp %h", d4_instr_o, NOP); end
        checks++; if (d4_pc_o !== 64'h0) begin errors++; $display("FAIL flush_pc got %h exp 0", d4_pc_o); end
        @(negedge clk);
        checks++; if (d4_valid_o !== 1'b0 || d4_pc_o === 64'h200) begin errors++; $display("FAIL flush_discard got v %0b pc %h exp v 0", d4_valid_o, d4_pc_o); end
        d4_ready_i = 1'b0;
        push_d4(64'h400);
        @(negedge clk);
        d4_valid_i = 1'b0;
        checks++; if (d4_occ !== 3'd1 || d4_pc_o !== 64'h400) begin errors++; $display("FAIL flush_post got occ %0d pc %h exp 1 400", d4_occ, d4_pc_o); end
        d4_ready_i = 1'b1;
        @(negedge clk);
        d4_ready_i = 1'b0;
        checks++; if (d4_occ !== 3'd0) begin errors++; $display("FAIL flush_post_drain got %0d exp 0", d4_occ); end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d2_valid_i = 1'b1; d2_ready_i = 1'b0;
            d2_pc_i = 64'h500 + 64'(4 * i); d2_instr_i = mk_instr(d2_pc_i);
        end
        @(negedge clk);
        checks++; if (d2_occ !== 2'd2 || d2_ready_o !== 1'b0) begin errors++; $display("FAIL fp_full got occ %0d r %0b exp 2 0", d2_occ, d2_ready_o); end
        d2_pc_i = 64'h508; d2_instr_i = mk_instr(64'h508); d2_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (d2_occ !== 2'd1) begin errors++; $display("FAIL fp_pop_only got occ %0d exp 1", d2_occ); end
        checks++; if (d2_pc_o !== 64'h504 || d2_ready_o !== 1'b1) begin errors++; $display("FAIL fp_head got pc %h r %0b exp 504 1", d2_pc_o, d2_ready_o); end
        d2_ready_i = 1'b0;
        @(negedge clk);
        d2_valid_i = 1'b0;
        checks++; if (d2_occ !== 2'd2 || d2_pc_o !== 64'h504) begin errors++; $display("FAIL fp_accept got occ %0d pc %h exp 2 504", d2_occ, d2_pc_o); end
        d2_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (d2_pc_o !== 64'h508 || d2_instr_o !== mk_instr(64'h508)) begin errors++; $display("FAIL fp_next got pc %h instr %h exp 508", d2_pc_o, d2_instr_o); end
        @(negedge clk);
        d2_ready_i = 1'b0;
        checks++; if (d2_occ !== 2'd0 || d2_valid_o !== 1'b0) begin errors++; $display("FAIL fp_empty got occ %0d v %0b exp 0 0", d2_occ, d2_valid_o); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            push_d4(64'h600 + 64'(4 * i));
            d4_ready_i = 1'b0;
        end
        @(negedge clk);
        d4_valid_i = 1'b0;
        checks++; if (d4_occ !== 3'd2) begin errors++; $display("FAIL ar_pre_occ got %0d exp 2", d4_occ); end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (d4_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid got %0b exp 0", d4_valid_o); end
        checks++; if (d4_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got %0b exp 1", d4_ready_o); end
        checks++; if (d4_occ !== 3'd0) begin errors++; $display("FAIL ar_occ got %0d exp 0", d4_occ); end
        checks++; if (d4_instr_o !== NOP) begin errors++; $display("FAIL ar_instr got %h exp %h", d4_instr_o, NOP); end
        checks++; if (d4_pc_o !== 64'h0) begin errors++; $display("FAIL ar_pc got %h exp 0", d4_pc_o); end
        @(negedge clk);
        reset_n = 1'b1;
        push_d4(64'h700);
        @(negedge clk);
        d4_valid_i = 1'b0;
        checks++; if (d4_occ !== 3'd1 || d4_pc_o !== 64'h700) begin errors++; $display("FAIL ar_first_push got occ %0d pc %h exp 1 700", d4_occ, d4_pc_o); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_streaming();
        test_wrap();
        test_flush();
        test_full_pop();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
